// File: rtl/conflict_batcher.sv
// conflict_batcher
//   Groups consecutive, mutually non-conflicting transactions from the insertion
//   queue into batches and then replays each batch as a burst of programIDs.
//   A batch closes when an incoming beat conflicts with it, when it is full, or
//   when no beat has been accepted for BATCH_TIMEOUT cycles.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_tvalid / s_axis_tready     input transaction handshake
//   s_axis_tdata_owner_programID      64-bit owner ID of the incoming transaction
//   s_axis_tdata_read_dependencies    read-set bitmap
//   s_axis_tdata_write_dependencies   write-set bitmap
//   m_axis_tvalid / m_axis_tready     batch member handshake
//   m_axis_tdata_owner_programID      programID of the current member
//   m_axis_tlast                      last member of the batch
//   m_axis_tbatch_id                  8-bit batch sequence number (wraps)
//   m_axis_tbatch_size                member count of the batch being drained
//   batches_emitted                   batches completed (TLAST handshakes)
//   conflicts_detected                batches closed by a conflicting beat
module conflict_batcher #(
  parameter int unsigned MAX_DEPENDENCIES = 256,
  parameter int unsigned MAX_BATCH_SIZE   = 8,
  parameter int unsigned BATCH_TIMEOUT    = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [63:0]                             s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]             s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]             s_axis_tdata_write_dependencies,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [63:0]                             m_axis_tdata_owner_programID,
  output logic                                    m_axis_tlast,
  output logic [7:0]                              m_axis_tbatch_id,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]     m_axis_tbatch_size,
  output logic [31:0]                             batches_emitted,
  output logic [31:0]                             conflicts_detected
);

  localparam int unsigned CW = $clog2(MAX_BATCH_SIZE + 1);
  localparam int unsigned AW = $clog2(MAX_BATCH_SIZE);
  localparam int unsigned IW = $clog2(BATCH_TIMEOUT + 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                      state;
  logic [63:0]                 batch_ids [MAX_BATCH_SIZE];
  logic [CW-1:0]               batch_count;
  logic [MAX_DEPENDENCIES-1:0] batch_rmask;
  logic [MAX_DEPENDENCIES-1:0] batch_wmask;

  logic                        carry_valid;
  logic [63:0]                 carry_id;
  logic [MAX_DEPENDENCIES-1:0] carry_rmask;
  logic [MAX_DEPENDENCIES-1:0] carry_wmask;

  logic [IW-1:0]               idle_cnt;
  logic [7:0]                  batch_id;
  logic [AW-1:0]               drain_idx;

  logic                        accept;
  logic                        conflict;
  logic [AW-1:0]               last_idx;

  // Ready only depends on registered state, never on s_axis_tvalid.
  assign s_axis_tready = (state == COLLECT) && !carry_valid;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Write-after-read, write-after-write and read-after-write overlaps conflict;
  // read-read sharing does not. An empty batch cannot conflict.
  assign conflict = (batch_count != '0) &&
                    ((|(s_axis_tdata_write_dependencies & (batch_rmask | batch_wmask))) ||
                     (|(s_axis_tdata_read_dependencies & batch_wmask)));

  // Only meaningful in DRAIN, where the batch always holds at least one member.
  assign last_idx = AW'(batch_count - CW'(1));

  assign m_axis_tvalid                = (state == DRAIN);
  assign m_axis_tdata_owner_programID = batch_ids[drain_idx];
  assign m_axis_tlast                 = (state == DRAIN) && (drain_idx == last_idx);
  assign m_axis_tbatch_id             = batch_id;
  assign m_axis_tbatch_size           = batch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= COLLECT;
      for (int unsigned i = 0; i < MAX_BATCH_SIZE; i++) batch_ids[i] <= '0;
      batch_count        <= '0;
      batch_rmask        <= '0;
      batch_wmask        <= '0;
      carry_valid        <= 1'b0;
      carry_id           <= '0;
      carry_rmask        <= '0;
      carry_wmask        <= '0;
      idle_cnt           <= '0;
      batch_id           <= '0;
      drain_idx          <= '0;
      batches_emitted    <= '0;
      conflicts_detected <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            idle_cnt <= '0;
            if (conflict) begin
              // Park the conflicting beat; it seeds the next batch after the drain.
              carry_valid        <= 1'b1;
              carry_id           <= s_axis_tdata_owner_programID;
              carry_rmask        <= s_axis_tdata_read_dependencies;
              carry_wmask        <= s_axis_tdata_write_dependencies;
              conflicts_detected <= conflicts_detected + 32'd1;
              state              <= DRAIN;
            end else begin
              batch_ids[batch_count[AW-1:0]] <= s_axis_tdata_owner_programID;
              batch_count <= batch_count + CW'(1);
              batch_rmask <= batch_rmask | s_axis_tdata_read_dependencies;
              batch_wmask <= batch_wmask | s_axis_tdata_write_dependencies;
              if (batch_count == CW'(MAX_BATCH_SIZE - 1)) state <= DRAIN;
            end
          end else if (batch_count != '0) begin
            if (idle_cnt == IW'(BATCH_TIMEOUT - 1)) begin
              idle_cnt <= '0;
              state    <= DRAIN;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end

        DRAIN: begin
          if (m_axis_tready) begin
            if (drain_idx == last_idx) begin
              batches_emitted <= batches_emitted + 32'd1;
              batch_id        <= batch_id + 8'd1;
              drain_idx       <= '0;
              idle_cnt        <= '0;
              state           <= COLLECT;
              if (carry_valid) begin
                batch_ids[0] <= carry_id;
                batch_count  <= CW'(1);
                batch_rmask  <= carry_rmask;
                batch_wmask  <= carry_wmask;
                carry_valid  <= 1'b0;
              end else begin
                batch_count <= '0;
                batch_rmask <= '0;
                batch_wmask <= '0;
              end
            end else begin
              drain_idx <= drain_idx + AW'(1);
            end
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_conflict_batcher.sv
// tb_conflict_batcher
//   Directed and randomized checks of conflict_batcher against a transaction-level
//   model: batches are lists of IDs with accumulated read/write sets, closed on
//   conflict, when full, or on an idle timeout.
module tb_conflict_batcher;

  localparam int unsigned DEPS = 256;
  localparam int unsigned MAXB = 8;
  localparam int unsigned TMO  = 64;
  localparam int unsigned SW   = $clog2(MAXB + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_tvalid;
  logic            s_tready;
  logic [63:0]     s_id;
  logic [DEPS-1:0] s_r;
  logic [DEPS-1:0] s_w;
  logic            m_tvalid;
  logic            m_tready;
  logic [63:0]     m_tdata;
  logic            m_tlast;
  logic [7:0]      m_bid;
  logic [SW-1:0]   m_size;
  logic [31:0]     batches_emitted;
  logic [31:0]     conflicts_detected;

  always #5 clk = ~clk;

  conflict_batcher #(
    .MAX_DEPENDENCIES (DEPS),
    .MAX_BATCH_SIZE   (MAXB),
    .BATCH_TIMEOUT    (TMO)
  ) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_tvalid),
    .s_axis_tready                   (s_tready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_r),
    .s_axis_tdata_write_dependencies (s_w),
    .m_axis_tvalid                   (m_tvalid),
    .m_axis_tready                   (m_tready),
    .m_axis_tdata_owner_programID    (m_tdata),
    .m_axis_tlast                    (m_tlast),
    .m_axis_tbatch_id                (m_bid),
    .m_axis_tbatch_size              (m_size),
    .batches_emitted                 (batches_emitted),
    .conflicts_detected              (conflicts_detected)
  );

  typedef struct {
    logic [63:0]   id;
    logic          last;
    logic [7:0]    bid;
    logic [SW-1:0] size;
  } beat_t;

  beat_t obs_q [$];
  beat_t exp_q [$];
  int    obs_rd = 0;

  // Output monitor: records every member handshake.
  always @(posedge clk) begin
    if (rst_n && m_tvalid && m_tready)
      obs_q.push_back('{m_tdata, m_tlast, m_bid, m_size});
  end

  // Reference model state
  logic [63:0]     cur_ids [$];
  logic [DEPS-1:0] cur_r;
  logic [DEPS-1:0] cur_w;
  logic [7:0]      m_next_bid;
  int unsigned     m_emitted;
  int unsigned     m_conf;

  int   checks = 0;
  int   errors = 0;
  logic rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic close_batch();
    int sz;
    sz = cur_ids.size();
    for (int i = 0; i < sz; i++)
      exp_q.push_back('{cur_ids[i], 1'(i == sz - 1), m_next_bid, SW'(sz)});
    m_next_bid++;
    m_emitted++;
    cur_ids.delete();
    cur_r = '0;
    cur_w = '0;
  endtask

  task automatic model_accept(input logic [63:0] id, input logic [DEPS-1:0] r,
                              input logic [DEPS-1:0] w);
    bit clash;
    clash = (cur_ids.size() > 0) && (((w & (cur_r | cur_w)) != '0) || ((r & cur_w) != '0));
    if (clash) begin
      close_batch();
      m_conf++;
    end
    cur_ids.push_back(id);
    cur_r = cur_r | r;
    cur_w = cur_w | w;
    if (cur_ids.size() == MAXB) close_batch();
  endtask

  task automatic model_timeout();
    if (cur_ids.size() > 0) close_batch();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cur_ids.delete();
    cur_r      = '0;
    cur_w      = '0;
    m_next_bid = '0;
    m_emitted  = 0;
    m_conf     = 0;
    exp_q.delete();
    obs_rd = obs_q.size();
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_bid_size", {m_bid, m_size}, 0);
    chk("rst_counters", {batches_emitted, conflicts_detected}, 0);
    chk("rst_s_tready", s_tready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_tready", s_tready, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] id, input logic [DEPS-1:0] r, input logic [DEPS-1:0] w);
    bit ok;
    ok = 0;
    s_tvalid = 1'b1;
    s_id = id;
    s_r = r;
    s_w = w;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (s_tready) begin
        @(posedge clk);
        ok = 1;
        model_accept(id, r, w);
      end
      tick();
    end
    s_tvalid = 1'b0;
    chk("send_accepted", 64'(ok), 1);
  endtask

  task automatic wait_tvalid(output int cycles);
    cycles = 0;
    while (!m_tvalid && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_batches(input string tag);
    int n;
    int got;
    n = 0;
    while ((obs_q.size() - obs_rd) < exp_q.size() && n < 5000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    got = obs_q.size() - obs_rd;
    chk({tag, "_beats"}, 64'(got), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      chk({tag, "_id"}, obs_q[obs_rd + i].id, exp_q[i].id);
      chk({tag, "_last_bid_size"},
          {obs_q[obs_rd + i].last, obs_q[obs_rd + i].bid, obs_q[obs_rd + i].size},
          {exp_q[i].last, exp_q[i].bid, exp_q[i].size});
    end
    obs_rd += got;
    exp_q.delete();
    chk({tag, "_batches_emitted"}, batches_emitted, 64'(m_emitted));
    chk({tag, "_conflicts"}, conflicts_detected, 64'(m_conf));
  endtask

  function automatic logic [DEPS-1:0] bit_at(input int b);
    logic [DEPS-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    int              cyc;
    logic [63:0]     hold_id;
    logic [10:0]     hold_ctl;
    logic [4:0]      pat;
    logic [DEPS-1:0] rr;
    logic [DEPS-1:0] ww;

    s_tvalid = 1'b0;
    s_id     = '0;
    s_r      = '0;
    s_w      = '0;
    m_tready = 1'b1;
    do_reset();

    // Three disjoint writers, closed by the idle timeout.
    send(64'd1, '0, bit_at(0));
    send(64'd2, '0, bit_at(1));
    send(64'd3, '0, bit_at(2));
    wait_tvalid(cyc);
    chk("timeout_cycles", 64'(cyc), 64'(TMO));
    model_timeout();
    check_batches("t1");

    // Write then read of the same bit: conflict, second beat seeds the next batch.
    do_reset();
    send(64'hA, '0, bit_at(5));
    send(64'hB, bit_at(5), '0);
    check_batches("t2a");
    wait_tvalid(cyc);
    chk("t2_seed_size", m_size, 1);
    model_timeout();
    check_batches("t2b");

    // Read-read sharing does not conflict.
    do_reset();
    send(64'hA, bit_at(7), '0);
    send(64'hB, bit_at(7), '0);
    wait_tvalid(cyc);
    model_timeout();
    check_batches("t3");

    // Nine disjoint beats: full batch of eight, ninth waits for the drain.
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(64'(16 + i), '0, bit_at(i + 20));
    chk("t4_s_tready_drain", s_tready, 0);
    chk("t4_tvalid_size", {m_tvalid, m_size}, {1'b1, SW'(MAXB)});
    hold_id = m_tdata;
    repeat (3) tick();
    chk("t4_hold_data", m_tdata, hold_id);
    chk("t4_hold_data_exp", m_tdata, 64'd16);
    m_tready = 1'b1;
    send(64'd99, '0, bit_at(100));
    check_batches("t4a");
    wait_tvalid(cyc);
    model_timeout();
    check_batches("t4b");

    // Backpressure pattern during a three-member drain.
    do_reset();
    m_tready = 1'b0;
    send(64'h11, '0, bit_at(1));
    send(64'h22, '0, bit_at(2));
    send(64'h33, '0, bit_at(3));
    wait_tvalid(cyc);
    model_timeout();
    pat = 5'b11001;  // applied LSB first: 1,0,0,1,1
    hold_id  = m_tdata;
    hold_ctl = {m_tlast, m_bid, 2'b00};
    for (int k = 0; k < 5; k++) begin
      m_tready = pat[k];
      tick();
      if (!pat[k]) begin
        chk("t5_stable_data", m_tdata, hold_id);
        chk("t5_stable_ctl", {m_tlast, m_bid, 2'b00}, hold_ctl);
      end
      hold_id  = m_tdata;
      hold_ctl = {m_tlast, m_bid, 2'b00};
    end
    chk("t5_tvalid_after", m_tvalid, 0);
    m_tready = 1'b1;
    check_batches("t5");

    // Reset in the middle of draining a four-member batch.
    send(64'h40, '0, bit_at(40));
    send(64'h41, '0, bit_at(41));
    send(64'h42, '0, bit_at(42));
    send(64'h43, '0, bit_at(43));
    wait_tvalid(cyc);
    model_timeout();
    tick();
    tick();
    chk("t6_mid_drain_id", m_tdata, exp_q[2].id);
    do_reset();
    send(64'h50, '0, bit_at(50));
    wait_tvalid(cyc);
    model_timeout();
    check_batches("t6");

    // Randomized traffic with random backpressure.
    do_reset();
    rand_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      rr = '0;
      ww = '0;
      rr[15:0] = 16'($urandom & $urandom & $urandom);
      ww[15:0] = 16'($urandom & $urandom & $urandom & $urandom);
      rr[DEPS-1] = ($urandom_range(0, 7) == 0);
      ww[DEPS-1] = ($urandom_range(0, 15) == 0);
      send({$urandom, $urandom}, rr, ww);
    end
    model_timeout();
    check_batches("rand");
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conflict_batcher.md
Name: conflict_batcher

Overview:
- Sits directly downstream of the insertion queue and consumes its AXI-Stream of transactions (owner programID plus read/write dependency bitmaps).
- Groups consecutive mutually non-conflicting transactions into batches for parallel execution.
- Emits each closed batch as a burst of member programIDs, with a batch ID, size and TLAST.
- A batch closes on a dependency conflict, when full, or on an idle timeout.

Parameters:
MAX_DEPENDENCIES, 256, width of read/write dependency bitmaps
MAX_BATCH_SIZE, 8, maximum transactions per batch (power of two not required, >=2)
BATCH_TIMEOUT, 64, idle cycles with a non-empty batch and no accept before forced close

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_axis_tvalid  input  1  input transaction valid
s_axis_tready  output  1  input ready
s_axis_tdata_owner_programID  input  64  transaction owner ID
s_axis_tdata_read_dependencies  input  MAX_DEPENDENCIES  read set
s_axis_tdata_write_dependencies  input  MAX_DEPENDENCIES  write set
m_axis_tvalid  output  1  batch member valid
m_axis_tready  input  1  downstream ready
m_axis_tdata_owner_programID  output  64  member programID
m_axis_tlast  output  1  last member of batch
m_axis_tbatch_id  output  8  batch sequence number
m_axis_tbatch_size  output  $clog2(MAX_BATCH_SIZE+1)  member count of current batch
batches_emitted  output  32  completed batches (TLAST handshakes)
conflicts_detected  output  32  batches closed by conflict

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All outputs and counters reset to 0, state COLLECT, batch empty, carry invalid.
- State storage:
  - batch_ids[0:MAX_BATCH_SIZE-1] (64b each), batch_count, batch_rmask, batch_wmask.
  - Carry register: valid, id, rmask, wmask.
  - idle counter, batch_id, drain index.
- s_axis_tready = (state==COLLECT) && !carry_valid. It is combinational from registered state only and never depends on tvalid.
- Conflict, evaluated on the input beat: |(in_w & (batch_rmask|batch_wmask)) OR |(in_r & batch_wmask).
  - Read-read overlap is not a conflict.
  - A transaction's own r/w overlap is ignored.
  - An empty batch never conflicts.
- COLLECT, on accept (tvalid&&tready):
  - No conflict:
    - ID written at batch_ids[batch_count]; count+1; masks OR-ed in; idle counter cleared.
    - If the new count == MAX_BATCH_SIZE, go to DRAIN on the same edge.
  - Conflict:
    - Beat stored in the carry register; batch unchanged; conflicts_detected+1; go to DRAIN.
- COLLECT, no accept:
  - If count>0, idle+1.
  - When idle reaches BATCH_TIMEOUT, go to DRAIN and clear idle.
  - If count==0, idle holds at 0.
- DRAIN:
  - m_axis_tvalid=1.
  - tdata = batch_ids[drain_idx]; tbatch_size = batch_count; tbatch_id = batch_id; tlast = (drain_idx==batch_count-1).
  - drain_idx advances only on m_axis_tready. Outputs are held stable while tready is low.
- On the TLAST handshake:
  - m_axis_tvalid deasserts the next cycle; batches_emitted+1; batch_id+1 (8-bit wrap 255->0); drain_idx=0; masks cleared.
  - If carry is valid: seed the batch with carry (count=1, masks=carry masks), clear carry.
  - Else count=0.
  - Return to COLLECT.
- Latency: accept to batch update is 1 cycle. Closing edge to first m_axis_tvalid is 1 cycle. A batch of N drains in N cycles under continuous tready.
- m_axis_tvalid is 0 in COLLECT.
- An asserted reset mid-DRAIN discards the batch and carry and returns to the reset state immediately.
- Counters wrap at 2^32.

Test Plan:
- Three txs with IDs 1,2,3, write sets bits {0},{1},{2}, then idle -> after 64 idle cycles one batch: IDs 1,2,3, size 3, tlast on 3, batch_id 0; batches_emitted=1.
- Tx A write bit5, then Tx B read bit5 -> batch {A} size 1 emitted, conflicts_detected=1; B seeded as next batch (count 1), emitted after timeout with batch_id 1.
- Txs A,B both reading bit7 only -> no conflict, single batch of size 2.
- 9 disjoint txs back-to-back -> first 8 emitted as batch size 8 (tready low during drain); 9th accepted after TLAST, forms batch_id 1.
- Batch of 3 with m_axis_tready toggling 1,0,0,1,1 -> data/tlast stable while low; IDs delivered in order; exactly 3 handshakes.
- Assert rst_n low during drain of a 4-member batch at index 2 -> m_axis_tvalid=0, counters 0, s_axis_tready=1 after release; next batch_id=0.
